dma_bus_arbiter: RTL and testbench



---
 rtl/dma_bus_arbiter_pkg.sv | 13 +
 rtl/dma_bus_arbiter_picker.sv | 29 ++
 rtl/dma_bus_arbiter.sv | 117 +++++++++++
 tb/tb_dma_bus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types for the DMA bus arbiter: FSM state encoding and watchdog counter width.
package dma_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BEGIN = 2'd1,
        ACTIVE     = 2'd2,
        RELEASE    = 2'd3
    } arb_state_e;

    localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/dma_bus_arbiter_picker.sv
// Combinational round-robin picker: first requester above lastGrant, wrapping modulo N.
module rr_priority_picker
    import dma_bus_arbiter_pkg::*;
#(
    parameter  int NR_OF_MASTERS = 4,
    localparam int IDX_W         = $clog2(NR_OF_MASTERS)
) (
    input  logic [NR_OF_MASTERS-1:0] request,
    input  logic [IDX_W-1:0]         lastGrant,
    output logic [IDX_W-1:0]         winnerIndex,
    output logic                     anyRequest
);

    logic found;

    // lastGrant itself is visited last, so a repeat owner only wins when alone.
    always_comb begin
        winnerIndex = lastGrant;
        found       = 1'b0;
        for (int i = 1; i <= NR_OF_MASTERS; i++) begin
            if (!found && request[IDX_W'((int'(lastGrant) + i) % NR_OF_MASTERS)]) begin
                winnerIndex = IDX_W'((int'(lastGrant) + i) % NR_OF_MASTERS);
                found       = 1'b1;
            end
        end
        anyRequest = |request;
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Round-robin owner FSM for the shared system bus; optional hang watchdog
// enabled by defining DMA_BUS_ARBITER_TIMEOUT_EN.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter  int NR_OF_MASTERS  = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W          = $clog2(NR_OF_MASTERS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NR_OF_MASTERS-1:0] request,
    output logic [NR_OF_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]         grantedIndex,
    output logic                     busOwned,
    input  logic                     beginTransactionIn,
    input  logic                     endTransactionIn,
    input  logic                     busErrorIn,
    output logic                     endTransactionOut,
    output logic                     busErrorOut
);

    if (NR_OF_MASTERS < 2 || NR_OF_MASTERS > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_params
        $error("dma_bus_arbiter: parameter out of range");
    end

    arb_state_e       state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic             any_request;
    logic             hung;
    logic             abort_pulse;

    // A bus error only matters together with the end strobe, which alone already releases.
    logic unused_bus_error;
    assign unused_bus_error = busErrorIn;

    rr_priority_picker #(.NR_OF_MASTERS(NR_OF_MASTERS)) u_picker (
        .request     (request),
        .lastGrant   (last_grant),
        .winnerIndex (winner),
        .anyRequest  (any_request)
    );

`ifdef DMA_BUS_ARBITER_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] wd_count;

    // Held at zero in IDLE, so it starts from zero on every grant.
    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            wd_count <= '0;
        end else if (state == WAIT_BEGIN || state == ACTIVE) begin
            wd_count <= wd_count + TIMEOUT_W'(1);
        end
    end

    assign hung = (state == WAIT_BEGIN || state == ACTIVE) && (wd_count == LAST_COUNT);
`else
    assign hung = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= '0;
            busOwned     <= 1'b0;
            grantedIndex <= '0;
            last_grant   <= IDX_W'(NR_OF_MASTERS - 1);
            abort_pulse  <= 1'b0;
        end else begin
            grant       <= '0;
            abort_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_request) begin
                        last_grant   <= winner;
                        grantedIndex <= winner;
                        grant        <= NR_OF_MASTERS'(1) << winner;
                        busOwned     <= 1'b1;
                        state        <= WAIT_BEGIN;
                    end
                end
                WAIT_BEGIN: begin
                    if (!request[grantedIndex]) begin
                        busOwned <= 1'b0;
                        state    <= RELEASE;
                    end else if (hung) begin
                        busOwned    <= 1'b0;
                        abort_pulse <= 1'b1;
                        state       <= RELEASE;
                    end else if (beginTransactionIn) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // A slave end on the timeout cycle wins over the watchdog.
                    if (endTransactionIn) begin
                        busOwned <= 1'b0;
                        state    <= RELEASE;
                    end else if (hung) begin
                        busOwned    <= 1'b0;
                        abort_pulse <= 1'b1;
                        state       <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign endTransactionOut = abort_pulse;
    assign busErrorOut       = abort_pulse;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: grant scoreboard plus per-scenario timing checks.
module tb_dma_bus_arbiter;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] request = '0;
    logic [N-1:0] grant;
    logic [1:0]   grantedIndex;
    logic         busOwned;
    logic         beginTransactionIn = 1'b0;
    logic         endTransactionIn = 1'b0;
    logic         busErrorIn = 1'b0;
    logic         endTransactionOut;
    logic         busErrorOut;

    int         pass_cnt = 0;
    int         check_cnt = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;
    bit         mon_en = 1'b0;

    dma_bus_arbiter #(.NR_OF_MASTERS(N), .TIMEOUT_CYCLES(8)) dut (
        .clock              (clock),
        .reset              (reset),
        .request            (request),
        .grant              (grant),
        .grantedIndex       (grantedIndex),
        .busOwned           (busOwned),
        .beginTransactionIn (beginTransactionIn),
        .endTransactionIn   (endTransactionIn),
        .busErrorIn         (busErrorIn),
        .endTransactionOut  (endTransactionOut),
        .busErrorOut        (busErrorOut)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000 time units");
        $fatal(1);
    end

    // Scoreboard: every grant pulse must match the next expected winner.
    always @(negedge clock) begin
        if (mon_en && grant !== '0) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("FAIL unexpected_grant: got grant=%b, required no grant", grant);
            end else begin
                mon_exp = exp_q.pop_front();
                check_cnt++;
                if (grant !== (4'b0001 << mon_exp)) $display("FAIL grant_vector: got %b, required %b", grant, 4'b0001 << mon_exp);
                else pass_cnt++;
                check_cnt++;
                if (grantedIndex !== mon_exp) $display("FAIL grant_index: got %0d, required %0d", grantedIndex, mon_exp);
                else pass_cnt++;
            end
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        request = '0;
        beginTransactionIn = 1'b0;
        endTransactionIn = 1'b0;
        busErrorIn = 1'b0;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    // Bounded wait for a grant pulse; n = negedges waited (30 means it never came).
    task automatic wait_grant(output int n);
        n = 0;
        while (grant === '0 && n < 30) begin
            step();
            n++;
        end
    endtask

    task automatic finish_txn();
        beginTransactionIn = 1'b1;
        step();
        beginTransactionIn = 1'b0;
        endTransactionIn = 1'b1;
        request = '0;
        step();
        endTransactionIn = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        check_cnt++;
        if (grant !== '0) $display("FAIL reset_grant: got %b, required 0000", grant); else pass_cnt++;
        check_cnt++;
        if (busOwned !== 1'b0) $display("FAIL reset_busowned: got %b, required 0", busOwned); else pass_cnt++;
        check_cnt++;
        if (grantedIndex !== 2'd0) $display("FAIL reset_index: got %0d, required 0", grantedIndex); else pass_cnt++;
        check_cnt++;
        if (endTransactionOut !== 1'b0) $display("FAIL reset_end_out: got %b, required 0", endTransactionOut); else pass_cnt++;
        check_cnt++;
        if (busErrorOut !== 1'b0) $display("FAIL reset_error_out: got %b, required 0", busErrorOut); else pass_cnt++;
    endtask

    task automatic test_single_master();
        int n;
        do_reset();
        request = 4'b0100;
        exp_q.push_back(2'd2);
        wait_grant(n);
        check_cnt++;
        if (n != 1) $display("FAIL single_latency: got %0d cycles, required 1", n); else pass_cnt++;
        check_cnt++;
        if (busOwned !== 1'b1) $display("FAIL single_owned: got %b, required 1", busOwned); else pass_cnt++;
        beginTransactionIn = 1'b1;
        step();
        beginTransactionIn = 1'b0;
        check_cnt++;
        if (grant !== '0) $display("FAIL single_pulse_width: got %b, required 0000", grant); else pass_cnt++;
        check_cnt++;
        if (busOwned !== 1'b1) $display("FAIL single_owned_active: got %b, required 1", busOwned); else pass_cnt++;
        repeat (4) step();
        endTransactionIn = 1'b1;
        request = '0;
        step();
        endTransactionIn = 1'b0;
        check_cnt++;
        if (busOwned !== 1'b0) $display("FAIL single_release: got %b, required 0", busOwned); else pass_cnt++;
        step();
        check_cnt++;
        if (busOwned !== 1'b0) $display("FAIL single_idle_owned: got %b, required 0", busOwned); else pass_cnt++;
        check_cnt++;
        if (grantedIndex !== 2'd2) $display("FAIL single_index_hold: got %0d, required 2", grantedIndex); else pass_cnt++;
        step();
    endtask

    task automatic test_fairness();
        int n;
        int prev;
        do_reset();
        request = 4'b1111;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        prev = -1;
        for (int t = 0; t < 5; t++) begin
            wait_grant(n);
            check_cnt++;
            if (n != ((t == 0) ? 1 : 2)) $display("FAIL rr_latency: txn %0d got %0d cycles, required %0d", t, n, (t == 0) ? 1 : 2);
            else pass_cnt++;
            if (t > 0) begin
                check_cnt++;
                if (int'(grantedIndex) == prev) $display("FAIL rr_no_repeat: got index %0d twice, required a different owner", grantedIndex);
                else pass_cnt++;
            end
            prev = int'(grantedIndex);
            beginTransactionIn = 1'b1;
            step();
            beginTransactionIn = 1'b0;
            step();
            endTransactionIn = 1'b1;
            if (t == 4) request = '0;
            step();
            endTransactionIn = 1'b0;
            check_cnt++;
            if (busOwned !== 1'b0) $display("FAIL rr_release: txn %0d got busOwned=%b, required 0", t, busOwned); else pass_cnt++;
        end
        step();
        step();
    endtask

    task automatic test_withdrawal();
        int n;
        do_reset();
        request = 4'b1010;
        exp_q.push_back(2'd1);
        wait_grant(n);
        request = 4'b1000;
        exp_q.push_back(2'd3);
        step();
        check_cnt++;
        if (busOwned !== 1'b0) $display("FAIL withdraw_release: got %b, required 0", busOwned); else pass_cnt++;
        wait_grant(n);
        check_cnt++;
        if (n != 2) $display("FAIL withdraw_regrant: got %0d cycles, required 2", n); else pass_cnt++;
        finish_txn();
    endtask

    task automatic test_reset_mid_active();
        int n;
        do_reset();
        request = 4'b0001;
        exp_q.push_back(2'd0);
        wait_grant(n);
        beginTransactionIn = 1'b1;
        step();
        beginTransactionIn = 1'b0;
        request = 4'b1111;
        step();
        reset = 1'b1;
        step();
        check_cnt++;
        if (busOwned !== 1'b0) $display("FAIL midreset_busowned: got %b, required 0", busOwned); else pass_cnt++;
        check_cnt++;
        if (grant !== '0) $display("FAIL midreset_grant: got %b, required 0000", grant); else pass_cnt++;
        check_cnt++;
        if (endTransactionOut !== 1'b0 || busErrorOut !== 1'b0)
            $display("FAIL midreset_pulses: got end=%b err=%b, required 0 0", endTransactionOut, busErrorOut);
        else pass_cnt++;
        exp_q.push_back(2'd0);
        reset = 1'b0;
        wait_grant(n);
        check_cnt++;
        if (n != 1) $display("FAIL midreset_regrant: got %0d cycles, required 1", n); else pass_cnt++;
        finish_txn();
    endtask

    task automatic test_watchdog();
        int n;
        int k;
        do_reset();
        request = 4'b0100;
        exp_q.push_back(2'd2);
        wait_grant(n);
        beginTransactionIn = 1'b1;
        step();
        beginTransactionIn = 1'b0;
        k = 1;
`ifdef DMA_BUS_ARBITER_TIMEOUT_EN
        while (endTransactionOut !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        check_cnt++;
        if (k != 8) $display("FAIL wd_latency: got %0d cycles after grant, required 8", k); else pass_cnt++;
        check_cnt++;
        if (busErrorOut !== 1'b1) $display("FAIL wd_error: got %b, required 1", busErrorOut); else pass_cnt++;
        check_cnt++;
        if (busOwned !== 1'b0) $display("FAIL wd_release: got %b, required 0", busOwned); else pass_cnt++;
        exp_q.push_back(2'd2);
        step();
        check_cnt++;
        if (endTransactionOut !== 1'b0 || busErrorOut !== 1'b0)
            $display("FAIL wd_pulse_width: got end=%b err=%b, required 0 0", endTransactionOut, busErrorOut);
        else pass_cnt++;
        wait_grant(n);
        check_cnt++;
        if (n != 1) $display("FAIL wd_rearbitrate: got %0d cycles, required 1", n); else pass_cnt++;
        finish_txn();
`else
        n = 0;
        repeat (120) begin
            step();
            k++;
            if (busOwned !== 1'b1) n++;
            if (endTransactionOut !== 1'b0 || busErrorOut !== 1'b0) n += 1000;
        end
        check_cnt++;
        if (n != 0) $display("FAIL hung_bus_held: got %0d bad cycles in %0d, required 0", n, k); else pass_cnt++;
        do_reset();
`endif
    endtask

`ifdef DMA_BUS_ARBITER_TIMEOUT_EN
    task automatic test_end_collision();
        int n;
        do_reset();
        request = 4'b0100;
        exp_q.push_back(2'd2);
        wait_grant(n);
        beginTransactionIn = 1'b1;
        step();
        beginTransactionIn = 1'b0;
        repeat (6) step();
        // The end strobe is sampled on the same edge the watchdog expires.
        endTransactionIn = 1'b1;
        request = '0;
        step();
        endTransactionIn = 1'b0;
        check_cnt++;
        if (busErrorOut !== 1'b0) $display("FAIL collision_error: got %b, required 0", busErrorOut); else pass_cnt++;
        check_cnt++;
        if (endTransactionOut !== 1'b0) $display("FAIL collision_end_out: got %b, required 0", endTransactionOut); else pass_cnt++;
        check_cnt++;
        if (busOwned !== 1'b0) $display("FAIL collision_release: got %b, required 0", busOwned); else pass_cnt++;
        step();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single_master();
        test_fairness();
        test_withdrawal();
        test_reset_mid_active();
        test_watchdog();
`ifdef DMA_BUS_ARBITER_TIMEOUT_EN
        test_end_collision();
`endif
        repeat (3) step();
        check_cnt++;
        if (exp_q.size() != 0) $display("FAIL queue_drained: got %0d pending grants, required 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
